// File: rtl/lsm_sequencer_pkg.sv
// Shared encodings for the load/store-multiple sequencer: control-word commands,
// sequencer states, addressing modes keyed on {P,U}, and the transfer word size.
package lsm_sequencer_pkg;

  typedef enum logic [2:0] {
    LSM_NOP   = 3'b000,
    LSM_LOAD  = 3'b001,
    LSM_NEXT  = 3'b010,
    LSM_CLEAR = 3'b011
  } lsm_cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10
  } lsm_state_e;

  // Addressing modes, indexed by {P, U} = {IR[24], IR[23]}
  localparam logic [1:0] DA = 2'b00;
  localparam logic [1:0] IA = 2'b01;
  localparam logic [1:0] DB = 2'b10;
  localparam logic [1:0] IB = 2'b11;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/lsm_prio_enc16.sv
// Lowest-set-bit priority encoder with popcount for a 16-entry register list.
// The index reads 0 when the list is empty.
module lsm_prio_enc16 (
  input  logic [15:0] list,
  output logic [3:0]  idx,
  output logic        valid,
  output logic [4:0]  count
);

  always_comb begin
    idx   = 4'd0;
    count = 5'd0;
    // Scan downwards so the last hit is the lowest set bit
    for (int i = 15; i >= 0; i--) begin
      if (list[i]) idx = 4'(i);
    end
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(list[i]);
    end
    valid = |list;
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Load/store-multiple register-list sequencer: walks IR[15:0] lowest register first,
// producing register number, transfer address and base writeback value.
module lsm_sequencer
  import lsm_sequencer_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW   = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LSM_EN,
  input  logic [2:0]    LSM_IN,
  input  logic [AW-1:0] IR,
  input  logic [AW-1:0] BASE,
  output logic          LSM_DETECT,
  output logic          LSM_END,
  output logic [3:0]    REG_NUM,
  output logic [AW-1:0] ADDR,
  output logic [AW-1:0] WB_VAL,
  output logic [4:0]    COUNT,
  output logic          BUSY
);

  lsm_state_e      state_reg;
  logic [NREG-1:0] pending_reg, pending_next;
  logic [AW-1:0]   addr_reg, wb_reg;
  logic [AW-1:0]   start_addr_next, wb_next, ofs, word;
  logic [4:0]      count_reg;
  logic [3:0]      reg_num_reg;
  logic [3:0]      enc_idx;
  logic [4:0]      enc_count;
  logic            enc_valid;
  logic            cmd_load, cmd_next, cmd_clear;
  logic            unused_ir_bits;

  assign cmd_load  = LSM_EN && (LSM_IN == LSM_LOAD);
  assign cmd_next  = LSM_EN && (LSM_IN == LSM_NEXT);
  assign cmd_clear = LSM_EN && (LSM_IN == LSM_CLEAR);
  assign unused_ir_bits = ^{IR[AW-1:25], IR[22:NREG]};

  always_comb begin
    pending_next = pending_reg;
    if (cmd_load)
      pending_next = IR[NREG-1:0];
    else if (cmd_clear)
      pending_next = '0;
    else if (cmd_next && state_reg == ACTIVE)
      pending_next = pending_reg & (pending_reg - NREG'(1));
  end

  // The encoder looks at the next pending list: on LOAD it yields n, otherwise
  // it pre-computes the registered REG_NUM/COUNT for the following cycle.
  lsm_prio_enc16 u_enc (
    .list  (pending_next),
    .idx   (enc_idx),
    .valid (enc_valid),
    .count (enc_count)
  );

  always_comb begin
    word = AW'(WORD_BYTES);
    ofs  = AW'({enc_count, 2'b00});
    case ({IR[24], IR[23]})
      IA:      start_addr_next = BASE;
      IB:      start_addr_next = BASE + word;
      DA:      start_addr_next = BASE - ofs + word;
      DB:      start_addr_next = BASE - ofs;
      default: start_addr_next = BASE;
    endcase
    wb_next = IR[23] ? (BASE + ofs) : (BASE - ofs);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      addr_reg    <= '0;
      wb_reg      <= '0;
      count_reg   <= '0;
      reg_num_reg <= '0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= enc_count;
      reg_num_reg <= enc_idx;
      if (cmd_load) begin
        addr_reg  <= start_addr_next;
        wb_reg    <= wb_next;
        state_reg <= enc_valid ? ACTIVE : DONE;
      end else if (cmd_clear) begin
        state_reg <= IDLE;
      end else if (cmd_next && state_reg == ACTIVE) begin
        addr_reg <= addr_reg + word;
        if (!enc_valid) state_reg <= DONE;
      end
    end
  end

  assign LSM_DETECT = |pending_reg;
  assign LSM_END    = (count_reg <= 5'd1);
  assign REG_NUM    = reg_num_reg;
  assign ADDR       = addr_reg;
  assign WB_VAL     = wb_reg;
  assign COUNT      = count_reg;
  assign BUSY       = (state_reg == ACTIVE);

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Load/store-multiple register-list sequencer for the microprogrammed ARM datapath.
- Sits directly downstream of the control unit: it consumes the control word's LSM_EN and LSM_IN2..0 fields together with IR.
- Sits directly upstream of the same control unit: it produces the LSM_DETECT and LSM_END condition inputs that the microsequencer tests.
- Scans IR[15:0] lowest register first and supplies the current register number, the transfer address and the base writeback value to the datapath.

Parameters:
- NREG, 16, width of the register list (one bit per architectural register).
- AW, 32, address and data width.

Ports:
- CLK  in  1  system clock; every register updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- LSM_EN  in  1  command qualifier taken from the control word.
- LSM_IN  in  3  command taken from the control word: 000 NOP, 001 LOAD, 010 NEXT, 011 CLEAR; 1xx reserved and treated as NOP.
- IR  in  AW  instruction register: [24]=P, [23]=U, [15:0]=register list.
- BASE  in  AW  value of Rn, sampled on LOAD.
- LSM_DETECT  out  1  transfers remain (pending list non-zero).
- LSM_END  out  1  current transfer is the last one, or no transfer remains.
- REG_NUM  out  4  index of the lowest pending register (0 when the list is empty).
- ADDR  out  AW  memory address of the current transfer.
- WB_VAL  out  AW  final base value for writeback.
- COUNT  out  5  number of pending registers.
- BUSY  out  1  high while state = ACTIVE.

Behaviour:
- Reset and idle:
  - Reset (also when asserted mid-operation): state IDLE, pending=0, ADDR=0, WB_VAL=0, COUNT=0, REG_NUM=0, LSM_DETECT=0, LSM_END=1, BUSY=0.
  - LSM_EN=0 means no state change, whatever LSM_IN carries.
- States:
  - IDLE: after reset or CLEAR.
  - ACTIVE: pending list non-zero.
  - DONE: list exhausted; ADDR and WB_VAL are held.
- LOAD (accepted in any state, restarts any operation in progress):
  - pending <= IR[15:0]; n = popcount(IR[15:0]).
  - Start ADDR by mode:
    - IA (P=0,U=1): BASE.
    - IB (P=1,U=1): BASE+4.
    - DA (P=0,U=0): BASE-4n+4.
    - DB (P=1,U=0): BASE-4n.
  - WB_VAL = BASE+4n when U=1, BASE-4n when U=0. Arithmetic is modulo 2^AW.
  - Next state ACTIVE if n>0, else DONE.
- NEXT:
  - In ACTIVE: clear the lowest set bit of pending; ADDR <= ADDR+4; COUNT decrements.
  - When the cleared bit was the last one, go to DONE.
  - NEXT in IDLE or DONE has no effect.
- CLEAR: pending=0, COUNT=0, state IDLE. ADDR and WB_VAL are held.
- Output timing:
  - All outputs are registered state or combinational decodes of registered state.
  - A command takes effect on the edge where it is sampled; outputs are valid in the following cycle (1-cycle latency).
- Derived outputs:
  - LSM_DETECT = (pending != 0).
  - LSM_END = (COUNT <= 1).
  - REG_NUM comes from a lowest-set-bit priority encode of pending.
  - Registers transfer in ascending order; the lowest-numbered register always goes to the lowest address.
- Empty list: LOAD with IR[15:0]=0 gives DETECT=0, END=1, COUNT=0, state DONE; ADDR and WB_VAL are computed with n=0.
- Full list 0xFFFF: n=16, so COUNT must hold 16 (5 bits) and the offset is 64.
- No handshake with memory: the control unit issues NEXT only after MOC, so the sequencer never stalls.

Decomposition:
- Shared package:
  - LSM_IN command encodings (LSM_NOP, LSM_LOAD, LSM_NEXT, LSM_CLEAR).
  - State encodings (IDLE, ACTIVE, DONE).
  - Mode constants IA, IB, DA, DB keyed on {P,U}.
  - Word size constant 4.
- One sub-module: lsm_prio_enc16.
  - Input: 16-bit list.
  - Outputs: lowest-set-bit index, a valid flag, and a 5-bit popcount.
  - The same instance serves both the LOAD count and REG_NUM.

Test Plan:
- IA, full cycle:
  - Stimulus: IR[24:23]=01, list=0x800F, BASE=0x100, LOAD.
  - After LOAD: REG_NUM=0, ADDR=0x100, COUNT=5, DETECT=1, END=0, WB_VAL=0x114.
  - After 4 NEXT: REG_NUM=15, ADDR=0x110, END=1.
  - 5th NEXT: DETECT=0, BUSY=0.
- DB:
  - Stimulus: P=1, U=0, list=0x4010, BASE=0x200, LOAD.
  - After LOAD: REG_NUM=4, ADDR=0x1F8, WB_VAL=0x1F8.
  - After one NEXT: REG_NUM=14, ADDR=0x1FC, END=1.
- IB single register: P=1, U=1, list=0x0001, BASE=0x300 -> ADDR=0x304, END=1, DETECT=1, WB_VAL=0x304.
- DA:
  - Stimulus: list=0x0006, BASE=0x400.
  - Required: r1 at 0x3FC, then r2 at 0x400; WB_VAL=0x3F8.
- Empty list and ignored commands:
  - LOAD with list=0 -> DETECT=0, END=1, COUNT=0.
  - NEXT with LSM_EN=0 in ACTIVE -> no change.
  - NEXT in DONE -> no change.
- Reset and reload:
  - RST asserted mid-ACTIVE -> all outputs at reset values next cycle.
  - LOAD while ACTIVE -> restarts with the new list and BASE.
